ahb_m2s_mux_pipelined: RTL and testbench

Parametrised AHB master-to-slave multiplexer that routes address/control from the granted master and routes write data from the master that owns the current data phase, one cycle later. It sits between the arbiter (which drives HMASTER) and the address decoder/slaves. It also tracks fixed-length bursts and flags protocol-level handover faults. HMASTER_D feeds the slave-to-master response routing.

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_m2s_mux_pipelined_if.sv | 48 ++++
 rtl/ahb_burst_tracker.sv | 46 ++++
 rtl/ahb_m2s_mux_pipelined.sv | 92 +++++++++
 tb/tb_ahb_m2s_mux_pipelined.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB transfer/burst encodings shared by the master-to-slave mux
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_t;

  // Undefined-length bursts (SINGLE, INCR) report 0 beats.
  function automatic logic [4:0] burst_beats(input hburst_t b);
    case (b)
      WRAP4, INCR4:   burst_beats = 5'd4;
      WRAP8, INCR8:   burst_beats = 5'd8;
      WRAP16, INCR16: burst_beats = 5'd16;
      default:        burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_m2s_mux_pipelined_if.sv
// rtl/ahb_m2s_mux_pipelined_if.sv - per-master request bundle and routed AHB address/data bus
interface ahb_m2s_mux_pipelined_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int MST_W = (NUM_MASTERS < 2) ? 1 : $clog2(NUM_MASTERS);

  logic [MST_W-1:0]  HMASTER;
  logic              HREADY;
  logic [ADDR_W-1:0] HADDR_M     [NUM_MASTERS];
  logic [1:0]        HTRANS_M    [NUM_MASTERS];
  logic              HWRITE_M    [NUM_MASTERS];
  logic [2:0]        HSIZE_M     [NUM_MASTERS];
  logic [2:0]        HBURST_M    [NUM_MASTERS];
  logic [3:0]        HPROT_M     [NUM_MASTERS];
  logic              HMASTLOCK_M [NUM_MASTERS];
  logic [DATA_W-1:0] HWDATA_M    [NUM_MASTERS];

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic [DATA_W-1:0] HWDATA;
  logic [MST_W-1:0]  HMASTER_D;
  logic              DATA_ACTIVE;
  logic [3:0]        BURST_LEFT;
  logic              HANDOVER_ERR;
  logic              EARLY_TERM;

  modport master (
    output HMASTER, HREADY, HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M,
           HPROT_M, HMASTLOCK_M, HWDATA_M,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
           HMASTER_D, DATA_ACTIVE, BURST_LEFT, HANDOVER_ERR, EARLY_TERM
  );

  modport slave (
    input  HMASTER, HREADY, HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M,
           HPROT_M, HMASTLOCK_M, HWDATA_M,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
           HMASTER_D, DATA_ACTIVE, BURST_LEFT, HANDOVER_ERR, EARLY_TERM
  );

endinterface

// File: rtl/ahb_burst_tracker.sv
// rtl/ahb_burst_tracker.sv - fixed-length burst beat counter with early-termination flag
module ahb_burst_tracker
  import ahb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hready_i,
  input  htrans_t    htrans_i,
  input  hburst_t    hburst_i,
  input  logic       master_chg_i,
  output logic [3:0] burst_left_o,
  output logic       early_term_o
);

  logic [3:0] left_q, left_d;
  logic       early_q, early_d;
  logic [4:0] beats;

  always_comb begin
    beats   = burst_beats(hburst_i);
    early_d = hready_i && master_chg_i && (left_q != 4'd0);
    left_d  = left_q;
    // A new NONSEQ wins over the early-termination clear.
    if (hready_i && htrans_i == NONSEQ) begin
      left_d = (beats == 5'd0) ? 4'd0 : 4'(beats - 5'd1);
    end else if (early_d) begin
      left_d = 4'd0;
    end else if (hready_i && htrans_i == SEQ && left_q != 4'd0) begin
      left_d = left_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      left_q  <= 4'd0;
      early_q <= 1'b0;
    end else begin
      left_q  <= left_d;
      early_q <= early_d;
    end
  end

  assign burst_left_o = left_q;
  assign early_term_o = early_q;

endmodule

// File: rtl/ahb_m2s_mux_pipelined.sv
// rtl/ahb_m2s_mux_pipelined.sv - AHB master-to-slave mux: combinational address routing,
// one-cycle-delayed write-data routing and handover fault detection
module ahb_m2s_mux_pipelined
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic HCLK,
  input logic HRESET,
  ahb_m2s_mux_pipelined_if.slave bus
);

  localparam int MST_W = (NUM_MASTERS < 2) ? 1 : $clog2(NUM_MASTERS);
  localparam logic [MST_W:0] NM = NUM_MASTERS[MST_W:0];

  logic             sel_valid, wdata_valid, accept, master_chg;
  logic [MST_W-1:0] hmaster_d_q, hmaster_d_d, last_master_q;
  logic             data_active_q, data_active_d;
  logic             hready_prev_q, handover_err_q, handover_err_d;

  assign sel_valid   = {1'b0, bus.HMASTER} < NM;
  assign wdata_valid = {1'b0, hmaster_d_q} < NM;
  assign master_chg  = bus.HMASTER != last_master_q;

  always_comb begin
    bus.HADDR     = {ADDR_W{1'b0}};
    bus.HTRANS    = IDLE;
    bus.HWRITE    = 1'b0;
    bus.HSIZE     = 3'd0;
    bus.HBURST    = SINGLE;
    bus.HPROT     = 4'd0;
    bus.HMASTLOCK = 1'b0;
    if (sel_valid) begin
      bus.HADDR     = bus.HADDR_M[bus.HMASTER];
      bus.HTRANS    = bus.HTRANS_M[bus.HMASTER];
      bus.HWRITE    = bus.HWRITE_M[bus.HMASTER];
      bus.HSIZE     = bus.HSIZE_M[bus.HMASTER];
      bus.HBURST    = bus.HBURST_M[bus.HMASTER];
      bus.HPROT     = bus.HPROT_M[bus.HMASTER];
      bus.HMASTLOCK = bus.HMASTLOCK_M[bus.HMASTER];
    end
  end

  assign accept = bus.HREADY && (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ);

  always_comb begin
    hmaster_d_d    = hmaster_d_q;
    data_active_d  = data_active_q;
    if (bus.HREADY) begin
      hmaster_d_d   = bus.HMASTER;
      data_active_d = accept;
    end
    handover_err_d = !hready_prev_q && master_chg;
  end

  // hready_prev resets high so the first cycle out of reset is not seen as a wait state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hmaster_d_q    <= '0;
      data_active_q  <= 1'b0;
      last_master_q  <= '0;
      hready_prev_q  <= 1'b1;
      handover_err_q <= 1'b0;
    end else begin
      hmaster_d_q    <= hmaster_d_d;
      data_active_q  <= data_active_d;
      last_master_q  <= bus.HMASTER;
      hready_prev_q  <= bus.HREADY;
      handover_err_q <= handover_err_d;
    end
  end

  assign bus.HWDATA       = (data_active_q && wdata_valid) ? bus.HWDATA_M[hmaster_d_q]
                                                           : {DATA_W{1'b0}};
  assign bus.HMASTER_D    = hmaster_d_q;
  assign bus.DATA_ACTIVE  = data_active_q;
  assign bus.HANDOVER_ERR = handover_err_q;

  ahb_burst_tracker u_burst (
    .clk_i        (HCLK),
    .rst_i        (HRESET),
    .hready_i     (bus.HREADY),
    .htrans_i     (htrans_t'(bus.HTRANS)),
    .hburst_i     (hburst_t'(bus.HBURST)),
    .master_chg_i (master_chg),
    .burst_left_o (bus.BURST_LEFT),
    .early_term_o (bus.EARLY_TERM)
  );

endmodule

// File: tb/tb_ahb_m2s_mux_pipelined.sv
// tb/tb_ahb_m2s_mux_pipelined.sv - directed bench for the AHB master-to-slave mux
module tb_ahb_m2s_mux_pipelined;
  import ahb_pkg::*;

  logic HCLK;
  logic HRESET;
  int   checks;
  int   errors;

  ahb_m2s_mux_pipelined_if #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) bus4 ();
  ahb_m2s_mux_pipelined_if #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32)) bus3 ();

  ahb_m2s_mux_pipelined #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus4)
  );

  ahb_m2s_mux_pipelined #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32)) u_dut3 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus3)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req4(input int m, input logic [1:0] tr, input logic [2:0] bu,
                      input logic [31:0] addr);
    bus4.HTRANS_M[m] = tr;
    bus4.HBURST_M[m] = bu;
    bus4.HADDR_M[m]  = addr;
    bus4.HWRITE_M[m] = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) begin
      bus4.HADDR_M[i] = '0; bus4.HTRANS_M[i] = IDLE; bus4.HWRITE_M[i] = 1'b0;
      bus4.HSIZE_M[i] = 3'd2; bus4.HBURST_M[i] = SINGLE; bus4.HPROT_M[i] = 4'd0;
      bus4.HMASTLOCK_M[i] = 1'b0; bus4.HWDATA_M[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      bus3.HADDR_M[i] = '0; bus3.HTRANS_M[i] = IDLE; bus3.HWRITE_M[i] = 1'b0;
      bus3.HSIZE_M[i] = 3'd2; bus3.HBURST_M[i] = SINGLE; bus3.HPROT_M[i] = 4'd0;
      bus3.HMASTLOCK_M[i] = 1'b0; bus3.HWDATA_M[i] = '0;
    end
    bus3.HMASTER = 2'd0;
    bus3.HREADY  = 1'b1;

    // Single write from M2; address path is live even while reset is asserted.
    HRESET = 1'b1;
    bus4.HREADY  = 1'b1;
    bus4.HMASTER = 2'd2;
    req4(2, NONSEQ, SINGLE, 32'h100);
    bus4.HWDATA_M[2] = 32'hDEADBEEF;
    #1;
    chk("rst_haddr_comb", bus4.HADDR, 32'h100);
    chk("rst_htrans_comb", 32'(bus4.HTRANS), 32'(NONSEQ));
    chk("rst_hwrite_comb", 32'(bus4.HWRITE), 32'd1);
    tick();
    chk("rst_hmaster_d", 32'(bus4.HMASTER_D), 32'd0);
    chk("rst_data_active", 32'(bus4.DATA_ACTIVE), 32'd0);
    chk("rst_burst_left", 32'(bus4.BURST_LEFT), 32'd0);
    chk("rst_handover", 32'(bus4.HANDOVER_ERR), 32'd0);
    chk("rst_early", 32'(bus4.EARLY_TERM), 32'd0);
    chk("rst_hwdata", bus4.HWDATA, 32'd0);
    HRESET = 1'b0;
    tick();
    chk("sw_hmaster_d", 32'(bus4.HMASTER_D), 32'd2);
    chk("sw_data_active", 32'(bus4.DATA_ACTIVE), 32'd1);
    chk("sw_hwdata", bus4.HWDATA, 32'hDEADBEEF);
    bus4.HWDATA_M[0] = 32'h12345678;
    #1;
    chk("sw_hwdata_m0_ignored", bus4.HWDATA, 32'hDEADBEEF);
    bus4.HTRANS_M[2] = IDLE;

    // Wait states: M1 owns the data phase while the grant moves to M3.
    bus4.HMASTER = 2'd1;
    req4(1, NONSEQ, SINGLE, 32'h200);
    bus4.HWDATA_M[1] = 32'hA1A1A1A1;
    tick();
    chk("ws_hmaster_d", 32'(bus4.HMASTER_D), 32'd1);
    bus4.HREADY = 1'b0;
    tick();
    chk("ws1_hmaster_d", 32'(bus4.HMASTER_D), 32'd1);
    chk("ws1_hwdata", bus4.HWDATA, 32'hA1A1A1A1);
    chk("ws1_handover", 32'(bus4.HANDOVER_ERR), 32'd0);
    bus4.HMASTER = 2'd3;
    bus4.HWDATA_M[1] = 32'hB2B2B2B2;
    #1;
    chk("ws2_hwdata_tracks", bus4.HWDATA, 32'hB2B2B2B2);
    tick();
    chk("ws2_handover_pulse", 32'(bus4.HANDOVER_ERR), 32'd1);
    chk("ws2_hmaster_d", 32'(bus4.HMASTER_D), 32'd1);
    tick();
    chk("ws3_handover_clear", 32'(bus4.HANDOVER_ERR), 32'd0);
    chk("ws3_hmaster_d", 32'(bus4.HMASTER_D), 32'd1);
    chk("ws3_hwdata", bus4.HWDATA, 32'hB2B2B2B2);
    bus4.HREADY = 1'b1;
    bus4.HTRANS_M[1] = IDLE;
    tick();
    chk("ws_end_hmaster_d", 32'(bus4.HMASTER_D), 32'd3);
    chk("ws_end_data_active", 32'(bus4.DATA_ACTIVE), 32'd0);

    // INCR8 by M0 with two BUSY cycles in the middle.
    bus4.HMASTER = 2'd0;
    req4(0, NONSEQ, INCR8, 32'h1000);
    tick();
    chk("incr8_load", 32'(bus4.BURST_LEFT), 32'd7);
    chk("incr8_no_early", 32'(bus4.EARLY_TERM), 32'd0);
    bus4.HTRANS_M[0] = SEQ;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("incr8_seq_a", 32'(bus4.BURST_LEFT), 32'(6 - i));
    end
    bus4.HTRANS_M[0] = BUSY;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("incr8_busy_hold", 32'(bus4.BURST_LEFT), 32'd4);
    end
    bus4.HTRANS_M[0] = SEQ;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("incr8_seq_b", 32'(bus4.BURST_LEFT), 32'(3 - i));
      chk("incr8_seq_no_early", 32'(bus4.EARLY_TERM), 32'd0);
    end
    tick();
    chk("incr8_saturate", 32'(bus4.BURST_LEFT), 32'd0);
    bus4.HTRANS_M[0] = IDLE;
    tick();

    // Early termination: WRAP4 from M0 loses the grant after two beats.
    req4(0, NONSEQ, WRAP4, 32'h2000);
    tick();
    chk("wrap4_load", 32'(bus4.BURST_LEFT), 32'd3);
    bus4.HTRANS_M[0] = SEQ;
    tick();
    chk("wrap4_seq", 32'(bus4.BURST_LEFT), 32'd2);
    bus4.HMASTER = 2'd1;
    bus4.HTRANS_M[1] = IDLE;
    tick();
    chk("et_pulse", 32'(bus4.EARLY_TERM), 32'd1);
    chk("et_burst_cleared", 32'(bus4.BURST_LEFT), 32'd0);
    tick();
    chk("et_pulse_end", 32'(bus4.EARLY_TERM), 32'd0);

    // Burst restart by the same master reloads without EARLY_TERM.
    req4(1, NONSEQ, INCR4, 32'h3000);
    tick();
    chk("rs_load4", 32'(bus4.BURST_LEFT), 32'd3);
    bus4.HTRANS_M[1] = SEQ;
    tick();
    chk("rs_seq", 32'(bus4.BURST_LEFT), 32'd2);
    req4(1, NONSEQ, INCR8, 32'h3100);
    tick();
    chk("rs_reload8", 32'(bus4.BURST_LEFT), 32'd7);
    chk("rs_no_early", 32'(bus4.EARLY_TERM), 32'd0);

    // Reset mid-INCR16 at BURST_LEFT=9, then INCR4 reloads.
    req4(1, NONSEQ, INCR16, 32'h4000);
    bus4.HWDATA_M[1] = 32'hC3C3C3C3;
    tick();
    chk("i16_load", 32'(bus4.BURST_LEFT), 32'd15);
    bus4.HTRANS_M[1] = SEQ;
    for (int i = 0; i < 6; i++) tick();
    chk("i16_mid", 32'(bus4.BURST_LEFT), 32'd9);
    HRESET = 1'b1;
    tick();
    chk("mrst_burst_left", 32'(bus4.BURST_LEFT), 32'd0);
    chk("mrst_data_active", 32'(bus4.DATA_ACTIVE), 32'd0);
    chk("mrst_hmaster_d", 32'(bus4.HMASTER_D), 32'd0);
    chk("mrst_hwdata", bus4.HWDATA, 32'd0);
    chk("mrst_early", 32'(bus4.EARLY_TERM), 32'd0);
    chk("mrst_handover", 32'(bus4.HANDOVER_ERR), 32'd0);
    HRESET = 1'b0;
    req4(1, NONSEQ, INCR4, 32'h5000);
    tick();
    chk("post_rst_load", 32'(bus4.BURST_LEFT), 32'd3);
    chk("post_rst_no_early", 32'(bus4.EARLY_TERM), 32'd0);
    bus4.HTRANS_M[1] = IDLE;

    // Out-of-range master index with NUM_MASTERS=3.
    bus3.HMASTER = 2'd2;
    bus3.HTRANS_M[2] = NONSEQ;
    bus3.HWRITE_M[2] = 1'b1;
    bus3.HADDR_M[2]  = 32'h300;
    bus3.HBURST_M[2] = INCR4;
    bus3.HWDATA_M[2] = 32'hCAFEF00D;
    tick();
    chk("n3_data_active", 32'(bus3.DATA_ACTIVE), 32'd1);
    chk("n3_hwdata", bus3.HWDATA, 32'hCAFEF00D);
    bus3.HMASTER = 2'd3;
    #1;
    chk("n3_inv_htrans", 32'(bus3.HTRANS), 32'(IDLE));
    chk("n3_inv_haddr", bus3.HADDR, 32'd0);
    chk("n3_inv_hwrite", 32'(bus3.HWRITE), 32'd0);
    chk("n3_inv_hburst", 32'(bus3.HBURST), 32'(SINGLE));
    tick();
    chk("n3_inv_data_active", 32'(bus3.DATA_ACTIVE), 32'd0);
    chk("n3_inv_hwdata", bus3.HWDATA, 32'd0);
    chk("n3_inv_hmaster_d", 32'(bus3.HMASTER_D), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
